conv_layer_sequencer: RTL and testbench

Parametrised control sequencer for one convolution layer. It supports any input/output channel count, feature-map size and kernel size, with true multi-input-channel accumulation. The loop order is output channel, then input channel, then window row and column. For each (out_ch, in_ch) pair it requests a kernel load, streams window coordinates and write addresses to the conv datapath and result register file, and optionally runs a 2x2 pooling pass per output channel. It replaces the fixed-size control FSM and channel counters at the conv layer top level, and adds a start/done handshake plus window and pool back-pressure.

---
 rtl/conv_pkg.sv | 18 +
 rtl/conv_layer_sequencer_window_scanner.sv | 39 +++
 rtl/conv_layer_sequencer.sv | 127 ++++++++++++
 tb/tb_conv_layer_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM state encoding, pool stride and min-1 clog2 helper for the conv layer sequencer
package conv_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_KLOAD,
    S_CONV,
    S_NEXT_CIN,
    S_POOL,
    S_NEXT_COUT,
    S_DONE
  } state_t;

  localparam int POOL_STRIDE = 2;

  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/conv_layer_sequencer_window_scanner.sv
// window_scanner: row/col/linear-address scan over an R x C grid, wrapping to zero after the last cell
module window_scanner #(
  parameter int R  = 1,
  parameter int C  = 1,
  parameter int RW = 1,
  parameter int CW = 1,
  parameter int AW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          advance,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic [AW-1:0] addr,
  output logic          last
);
  localparam logic [RW-1:0] RL = RW'(R - 1);
  localparam logic [CW-1:0] CL = CW'(C - 1);

  assign last = (row == RL) && (col == CL);

  // Address tracks row*C+col by counting accepts, so no multiplier is needed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row  <= '0;
      col  <= '0;
      addr <= '0;
    end else if (clear || (advance && last)) begin
      row  <= '0;
      col  <= '0;
      addr <= '0;
    end else if (advance) begin
      col  <= (col == CL) ? '0 : col + CW'(1);
      row  <= (col == CL) ? row + RW'(1) : row;
      addr <= addr + AW'(1);
    end
  end
endmodule

// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer: out_ch/in_ch/window loop control for one conv layer; optional 2x2 pool pass with CONV_SEQ_POOL_EN
module conv_layer_sequencer
  import conv_pkg::*;
#(
  parameter int H  = 28,
  parameter int W  = 28,
  parameter int K  = 3,
  parameter int OC = 8,
  parameter int IC = 1
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic                                                   start,
  output logic                                                   busy,
  output logic                                                   done,
  output logic [clog2_min1(OC)-1:0]                              out_ch,
  output logic [clog2_min1(IC)-1:0]                              in_ch,
  output logic                                                   kload_req,
  input  logic                                                   kload_ack,
  output logic                                                   win_valid,
  input  logic                                                   win_ready,
  output logic [clog2_min1(H-K+1)-1:0]                           win_row,
  output logic [clog2_min1(W-K+1)-1:0]                           win_col,
  output logic [clog2_min1((H-K+1)*(W-K+1))-1:0]                 out_addr,
  output logic                                                   first_write,
  output logic                                                   last_in_ch,
  output logic                                                   pool_valid,
  input  logic                                                   pool_ready,
  output logic [clog2_min1(((H-K+1)/POOL_STRIDE)*((W-K+1)/POOL_STRIDE))-1:0] pool_addr
);
  localparam int OH  = H - K + 1;
  localparam int OW  = W - K + 1;
  localparam int OCW = clog2_min1(OC);
  localparam int ICW = clog2_min1(IC);
  localparam int RW  = clog2_min1(OH);
  localparam int CW  = clog2_min1(OW);
  localparam int AW  = clog2_min1(OH * OW);

  state_t state, nxt;
  logic   win_last, in_last, out_last;

  assign in_last     = in_ch == ICW'(IC - 1);
  assign out_last    = out_ch == OCW'(OC - 1);
  assign busy        = state != S_IDLE;
  assign done        = state == S_DONE;
  assign kload_req   = state == S_KLOAD;
  assign win_valid   = state == S_CONV;
  assign first_write = busy && (in_ch == '0);
  assign last_in_ch  = busy && in_last;

  window_scanner #(.R(OH), .C(OW), .RW(RW), .CW(CW), .AW(AW)) u_win (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state == S_IDLE),
    .advance(win_valid && win_ready),
    .row    (win_row),
    .col    (win_col),
    .addr   (out_addr),
    .last   (win_last)
  );

`ifdef CONV_SEQ_POOL_EN
  localparam int PH = OH / POOL_STRIDE;
  localparam int PW = OW / POOL_STRIDE;
  localparam bit HAS_POOL = (PH * PW) > 0;
  localparam int PAW = clog2_min1(PH * PW);
  logic                         pool_last;
  logic [clog2_min1(PH)-1:0]    pool_row_unused;
  logic [clog2_min1(PW)-1:0]    pool_col_unused;
  assign pool_valid = state == S_POOL;
  window_scanner #(.R(PH), .C(PW), .RW(clog2_min1(PH)), .CW(clog2_min1(PW)), .AW(PAW)) u_pool (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state == S_IDLE),
    .advance(pool_valid && pool_ready),
    .row    (pool_row_unused),
    .col    (pool_col_unused),
    .addr   (pool_addr),
    .last   (pool_last)
  );
`else
  localparam bit HAS_POOL = 1'b0;
  logic pool_last;
  logic pool_unused;
  assign pool_valid  = 1'b0;
  assign pool_addr   = '0;
  assign pool_last   = 1'b0;
  assign pool_unused = pool_ready;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  // Next-state: channel loops wrap around the kernel-load / window-scan pass
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:      nxt = start ? S_KLOAD : S_IDLE;
      S_KLOAD:     nxt = kload_ack ? S_CONV : S_KLOAD;
      S_CONV:      nxt = (win_ready && win_last) ? S_NEXT_CIN : S_CONV;
      S_NEXT_CIN:  nxt = !in_last ? S_KLOAD : HAS_POOL ? S_POOL : S_NEXT_COUT;
      S_POOL:      nxt = (pool_valid && pool_ready && pool_last) ? S_NEXT_COUT : S_POOL;
      S_NEXT_COUT: nxt = out_last ? S_DONE : S_KLOAD;
      S_DONE:      nxt = S_IDLE;
      default:     nxt = S_IDLE;
    endcase
  end

  // Channel counters; they keep their final values after DONE until the next start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_ch <= '0;
      in_ch  <= '0;
    end else if (state == S_IDLE && start) begin
      out_ch <= '0;
      in_ch  <= '0;
    end else if (state == S_NEXT_CIN && !in_last) begin
      in_ch <= in_ch + ICW'(1);
    end else if (state == S_NEXT_COUT) begin
      in_ch  <= '0;
      out_ch <= out_last ? out_ch : out_ch + OCW'(1);
    end
  end
endmodule

// File: tb/tb_conv_layer_sequencer.sv
// tb_conv_layer_sequencer: randomized event-stream check of the conv layer sequencer against a loop-nest model
module tb_conv_layer_sequencer;
  localparam int H = 6, W = 6, K = 3, OC = 2, IC = 2;
  localparam int OH = H - K + 1, OW = W - K + 1, PH = OH / 2, PW = OW / 2;
`ifdef CONV_SEQ_POOL_EN
  localparam bit POOL = 1'b1;
`else
  localparam bit POOL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, start, kload_ack, win_ready, pool_ready;
  logic busy, done, kload_req, win_valid, first_write, last_in_ch, pool_valid;
  logic [0:0] out_ch, in_ch;
  logic [1:0] win_row, win_col, pool_addr;
  logic [3:0] out_addr;

  logic s_start, s_ack, s_ready, s_pready;
  logic s_busy, s_done, s_kreq, s_wv, s_fw, s_li, s_pv;
  logic [0:0] s_oc, s_ic, s_row, s_col, s_addr, s_paddr;

  always #5 clk = ~clk;

  conv_layer_sequencer #(.H(H), .W(W), .K(K), .OC(OC), .IC(IC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .out_ch(out_ch), .in_ch(in_ch), .kload_req(kload_req), .kload_ack(kload_ack),
    .win_valid(win_valid), .win_ready(win_ready), .win_row(win_row), .win_col(win_col),
    .out_addr(out_addr), .first_write(first_write), .last_in_ch(last_in_ch),
    .pool_valid(pool_valid), .pool_ready(pool_ready), .pool_addr(pool_addr)
  );

  conv_layer_sequencer #(.H(3), .W(3), .K(3), .OC(1), .IC(1)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .busy(s_busy), .done(s_done),
    .out_ch(s_oc), .in_ch(s_ic), .kload_req(s_kreq), .kload_ack(s_ack),
    .win_valid(s_wv), .win_ready(s_ready), .win_row(s_row), .win_col(s_col),
    .out_addr(s_addr), .first_write(s_fw), .last_in_ch(s_li),
    .pool_valid(s_pv), .pool_ready(s_pready), .pool_addr(s_paddr)
  );

  typedef struct {int kind; int oc; int ic; int r; int c; int a; int fw; int li;} ev_t;
  ev_t exp_q[$];
  int total = 0, bad = 0;
  int nwin = 0, nkl = 0;
  bit chk_en = 1'b0;
  int rmode = 0, kfix = 2;
  bit krand = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  function automatic ev_t mk(int kind, int oc, int ic, int r, int c, int a);
    ev_t e;
    e.kind = kind; e.oc = oc; e.ic = ic; e.r = r; e.c = c; e.a = a;
    e.fw = (ic == 0); e.li = (ic == IC - 1);
    return e;
  endfunction

  // Expected event stream of one layer run: kernel loads, windows, pool indices, done
  task automatic push_run();
    for (int o = 0; o < OC; o++) begin
      for (int i = 0; i < IC; i++) begin
        exp_q.push_back(mk(0, o, i, 0, 0, 0));
        for (int r = 0; r < OH; r++)
          for (int c = 0; c < OW; c++)
            exp_q.push_back(mk(1, o, i, r, c, r * OW + c));
      end
      if (POOL)
        for (int p = 0; p < PH * PW; p++) exp_q.push_back(mk(2, o, 0, 0, 0, p));
    end
    exp_q.push_back(mk(3, 0, 0, 0, 0, 0));
  endtask

  task automatic see(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL unexpected_event: got kind %0d want none", kind);
      return;
    end
    e = exp_q.pop_front();
    chk("ev_kind", kind, e.kind);
    if (kind != e.kind) return;
    if (kind == 0) begin
      chk("kl_oc", out_ch, e.oc); chk("kl_ic", in_ch, e.ic);
    end else if (kind == 1) begin
      chk("w_oc", out_ch, e.oc); chk("w_ic", in_ch, e.ic);
      chk("w_row", win_row, e.r); chk("w_col", win_col, e.c);
      chk("w_addr", out_addr, e.a); chk("w_fw", first_write, e.fw);
      chk("w_li", last_in_ch, e.li);
    end else if (kind == 2) begin
      chk("p_oc", out_ch, e.oc); chk("p_addr", pool_addr, e.a);
    end
  endtask

  logic prev_kreq = 1'b0, prev_stall = 1'b0, prev_ack = 1'b0;
  logic [8:0] prev_snap = '0;

  // Compare process: inputs and outputs are both stable at the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      if (prev_stall) chk("hold", {win_valid, win_row, win_col, out_addr}, prev_snap);
      if (prev_ack) chk("ack2win", win_valid, 1);
      if (!POOL) chk("no_pool", pool_valid, 0);
      if (kload_req && !prev_kreq) begin nkl++; see(0); end
      if (win_valid && win_ready) begin nwin++; see(1); end
      if (pool_valid && pool_ready) see(2);
      if (done) see(3);
    end
    prev_kreq  = kload_req;
    prev_ack   = kload_req && kload_ack;
    prev_stall = win_valid && !win_ready;
    prev_snap  = {win_valid, win_row, win_col, out_addr};
  end

  // Kernel loader: ack after a fixed or random delay, with spurious acks outside KLOAD in random mode
  initial begin
    int kcnt, kdel;
    kcnt = 0; kdel = 2; kload_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (kload_req && !kload_ack) begin
        if (kcnt >= kdel) begin
          kload_ack = 1'b1; kcnt = 0;
          kdel = krand ? int'($urandom_range(0, 3)) : kfix;
        end else kcnt++;
      end else begin
        kload_ack = krand && !kload_req && ($urandom_range(0, 7) == 0);
      end
    end
  end

  // Back-pressure generator: always ready, 1,0,0 pattern, or random
  initial begin
    int ph;
    ph = 0; win_ready = 1'b1; pool_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      win_ready  = (rmode == 0) ? 1'b1 : (rmode == 1) ? (ph % 3 == 0) : 1'($urandom_range(0, 1));
      pool_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      ph++;
    end
  end

  task automatic wait_empty();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 5000) begin @(negedge clk); n++; end
    chk("run_timeout", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run(input int mode, input bit kr);
    rmode = mode; krand = kr; nwin = 0; nkl = 0;
    push_run();
    chk_en = 1'b1;
    pulse_start();
    wait_empty();
    chk("nwin", nwin, 64);
    chk("nkl", nkl, 4);
    chk("final_oc", out_ch, 1);
    chk("final_ic", in_ch, 0);
    chk("busy_end", busy, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0); chk({tag, "_done"}, done, 0);
    chk({tag, "_kreq"}, kload_req, 0); chk({tag, "_wv"}, win_valid, 0);
    chk({tag, "_row"}, win_row, 0); chk({tag, "_col"}, win_col, 0);
    chk({tag, "_addr"}, out_addr, 0); chk({tag, "_oc"}, out_ch, 0);
    chk({tag, "_ic"}, in_ch, 0); chk({tag, "_fw"}, first_write, 0);
    chk({tag, "_li"}, last_in_ch, 0); chk({tag, "_pv"}, pool_valid, 0);
    chk({tag, "_pa"}, pool_addr, 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0;
    s_start = 1'b0; s_ack = 1'b0; s_ready = 1'b1; s_pready = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("rst");
    @(posedge clk); #1 rst_n = 1'b1;

    // Directed: start->kload_req latency of one cycle
    rmode = 0; krand = 1'b0; kfix = 2; nwin = 0; nkl = 0;
    push_run();
    chk_en = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(negedge clk); chk("kreq_before", kload_req, 0);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk); chk("kreq_lat1", kload_req, 1); chk("busy_run", busy, 1);
    wait_empty();
    chk("nwin", nwin, 64);
    chk("nkl", nkl, 4);

    run(1, 1'b0);
    run(2, 1'b1);
    run(2, 1'b1);

    // Reset in the middle of pass (1,1)
    rmode = 0; krand = 1'b0;
    push_run();
    pulse_start();
    n = 0;
    while (!(win_valid && out_ch == 1 && in_ch == 1 && win_row == 2) && n < 5000) begin
      @(negedge clk); n++;
    end
    chk("reach_pass11", n < 5000, 1);
    chk_en = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    #1 check_zero("arst");
    @(negedge clk); check_zero("arst_n");
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    run(2, 1'b1);

    // start held high through a run: ignored until IDLE, then restarts immediately
    rmode = 2; krand = 1'b1;
    push_run(); push_run();
    chk_en = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    n = 0;
    while (!done && n < 5000) begin @(negedge clk); n++; end
    chk("held_done", done, 1);
    @(negedge clk); chk("held_idle_busy", busy, 0); chk("held_idle_kreq", kload_req, 0);
    @(negedge clk); chk("held_restart", kload_req, 1); chk("held_oc0", out_ch, 0);
    @(posedge clk); #1 start = 1'b0;
    wait_empty();
    chk_en = 1'b0;

    // Single-window layer: H=W=K=3, OC=IC=1
    @(posedge clk); #1 s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    @(negedge clk); chk("s_kreq", s_kreq, 1); chk("s_wv0", s_wv, 0);
    @(posedge clk); #1 s_ack = 1'b1;
    @(posedge clk); #1 s_ack = 1'b0;
    @(negedge clk);
    chk("s_wv", s_wv, 1); chk("s_row", s_row, 0); chk("s_col", s_col, 0);
    chk("s_addr", s_addr, 0); chk("s_fw", s_fw, 1); chk("s_li", s_li, 1);
    @(negedge clk); chk("s_wv_off", s_wv, 0); chk("s_done_a", s_done, 0);
    @(negedge clk); chk("s_done_b", s_done, 0);
    @(negedge clk); chk("s_done", s_done, 1); chk("s_pv", s_pv, 0);
    @(negedge clk); chk("s_done_end", s_done, 0); chk("s_busy_end", s_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
